// File: rtl/dsp_delay_line.sv
// dsp_delay_line
//   Parametrised operand delay line for the DSP slice datapath. It has DEPTH
//   registered stages with a clock enable and a valid bit that travels with the
//   data. It also provides a synchronous flush and a runtime tap select, so one
//   instance can balance A/B/C/D/M/P path latency anywhere from 0 to DEPTH cycles.
//
// Ports
//   CLK      in   1      rising-edge clock
//   rst_n    in   1      asynchronous reset, active-low
//   CEN      in   1      clock enable; 0 holds stages and fill
//   clr      in   1      synchronous flush, wins over CEN
//   D        in   W      input data
//   D_vld    in   1      input valid
//   lat      in   LAT_W  selected latency; 0 = combinational bypass
//   Q        out  W      data from the selected tap
//   Q_vld    out  1      valid bit accompanying Q
//   fill     out  LAT_W  number of set valid bits across all stages
//   lat_err  out  1      sticky flag: lat > DEPTH was seen on a clock edge
module dsp_delay_line #(
    parameter int unsigned    W         = 18,
    parameter int unsigned    DEPTH     = 4,
    parameter int unsigned    LAT_W     = 5,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             CEN,
    input  logic             clr,
    input  logic [W-1:0]     D,
    input  logic             D_vld,
    input  logic [LAT_W-1:0] lat,
    output logic [W-1:0]     Q,
    output logic             Q_vld,
    output logic [LAT_W-1:0] fill,
    output logic             lat_err
);

    logic [DEPTH-1:0][W-1:0] stage_q, stage_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [LAT_W-1:0]        fill_q, fill_d;
    logic                    lat_err_q, lat_err_d;
    logic                    lat_bad;

    assign lat_bad = (lat > LAT_W'(DEPTH));

    always_comb begin
        stage_d   = stage_q;
        vld_d     = vld_q;
        fill_d    = fill_q;
        lat_err_d = lat_err_q | lat_bad;
        if (clr) begin
            stage_d   = {DEPTH{RESET_VAL}};
            vld_d     = '0;
            fill_d    = '0;
            lat_err_d = 1'b0;
        end else if (CEN) begin
            stage_d[0] = D;
            vld_d[0]   = D_vld;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
                vld_d[k]   = vld_q[k-1];
            end
            // Incremental popcount: one valid enters at stage 0 and one leaves from the last stage.
            fill_d = fill_q + LAT_W'(D_vld) - LAT_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= {DEPTH{RESET_VAL}};
            vld_q     <= '0;
            fill_q    <= '0;
            lat_err_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            vld_q     <= vld_d;
            fill_q    <= fill_d;
            lat_err_q <= lat_err_d;
        end
    end

    // Tap mux. Out-of-range latencies fall through to the last stage (clamp).
    always_comb begin
        Q     = stage_q[DEPTH-1];
        Q_vld = vld_q[DEPTH-1];
        if (lat == '0) begin
            Q     = D;
            Q_vld = D_vld;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (lat == LAT_W'(k + 1)) begin
                    Q     = stage_q[k];
                    Q_vld = vld_q[k];
                end
            end
        end
    end

    assign fill    = fill_q;
    assign lat_err = lat_err_q;

endmodule

// File: tb/tb_dsp_delay_line.sv
// tb_dsp_delay_line
//   Directed bench for dsp_delay_line (W=18, DEPTH=4). A queue scoreboard holds
//   the expected stage contents: entries are pushed when a shifting edge
//   captures D and dropped off the far end. Outputs are compared at mid-cycle.
module tb_dsp_delay_line;

    localparam int unsigned W     = 18;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT_W = 5;

    logic             CLK;
    logic             rst_n;
    logic             CEN;
    logic             clr;
    logic [W-1:0]     D;
    logic             D_vld;
    logic [LAT_W-1:0] lat;
    logic [W-1:0]     Q;
    logic             Q_vld;
    logic [LAT_W-1:0] fill;
    logic             lat_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [W-1:0] sb_data[$];
    logic         sb_vld[$];
    logic         sb_err;

    dsp_delay_line #(
        .W        (W),
        .DEPTH    (DEPTH),
        .LAT_W    (LAT_W),
        .RESET_VAL('0)
    ) dut (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .CEN    (CEN),
        .clr    (clr),
        .D      (D),
        .D_vld  (D_vld),
        .lat    (lat),
        .Q      (Q),
        .Q_vld  (Q_vld),
        .fill   (fill),
        .lat_err(lat_err)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_reset();
        sb_data.delete();
        sb_vld.delete();
        for (int i = 0; i < int'(DEPTH); i++) begin
            sb_data.push_back('0);
            sb_vld.push_back(1'b0);
        end
        sb_err = 1'b0;
    endtask

    function automatic int unsigned sb_fill();
        int unsigned n = 0;
        foreach (sb_vld[i]) n += int'(sb_vld[i]);
        return n;
    endfunction

    // Compare every output against the scoreboard for the current lat/D.
    task automatic chk_all(input string tag);
        int unsigned idx;
        logic [W-1:0] eq;
        logic         ev;
        if (lat == '0) begin
            eq = D;
            ev = D_vld;
        end else begin
            idx = (int'(lat) > int'(DEPTH)) ? DEPTH - 1 : int'(lat) - 1;
            eq  = sb_data[idx];
            ev  = sb_vld[idx];
        end
        chk({tag, " Q"},       32'(Q),       32'(eq));
        chk({tag, " Q_vld"},   32'(Q_vld),   32'(ev));
        chk({tag, " fill"},    32'(fill),    sb_fill());
        chk({tag, " lat_err"}, 32'(lat_err), 32'(sb_err));
    endtask

    // One rising edge; the scoreboard takes the same inputs the DUT sees, then we return at negedge.
    task automatic tick();
        @(posedge CLK);
        if (clr) begin
            sb_reset();
        end else begin
            if (int'(lat) > int'(DEPTH)) sb_err = 1'b1;
            if (CEN) begin
                sb_data.push_front(D);
                sb_vld.push_front(D_vld);
                void'(sb_data.pop_back());
                void'(sb_vld.pop_back());
            end
        end
        @(negedge CLK);
    endtask

    task automatic flush();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        int unsigned pat[5]   = '{1, 0, 1, 1, 0};
        int unsigned pfill[5] = '{1, 1, 2, 3, 2};

        rst_n = 1'b0; CEN = 1'b0; clr = 1'b0; D = '0; D_vld = 1'b0; lat = '0;
        sb_reset();
        repeat (2) @(negedge CLK);
        lat = 5'd1;
        #1 chk_all("reset");
        chk("reset fill const", 32'(fill), 0);
        rst_n = 1'b1;

        // Test 1: asynchronous reset mid-cycle with a populated pipe
        CEN = 1'b1; D = 18'h3FFFF; D_vld = 1'b1;
        repeat (3) tick();
        chk("pre-areset fill", 32'(fill), 3);
        #2 rst_n = 1'b0;
        sb_reset();
        for (int l = 1; l <= 4; l++) begin
            lat = LAT_W'(l);
            #1;
            chk($sformatf("areset L%0d Q", l), 32'(Q), 0);
            chk($sformatf("areset L%0d Q_vld", l), 32'(Q_vld), 0);
            chk($sformatf("areset L%0d fill", l), 32'(fill), 0);
        end
        lat = '0;
        #1 chk("areset L0 Q", 32'(Q), 32'h3FFFF);
        chk("areset L0 Q_vld", 32'(Q_vld), 1);
        rst_n = 1'b1;
        tick();
        chk_all("post-areset");

        // Test 2: latency sweep with a ramp
        for (int l = 0; l <= 4; l++) begin
            flush();
            lat = LAT_W'(l); D = 18'd1; D_vld = 1'b1; CEN = 1'b1;
            for (int e = 1; e <= 8; e++) begin
                tick();
                D = W'(e + 1);
                #1;
                chk_all($sformatf("sweep L%0d e%0d", l, e));
                if (e >= l) chk($sformatf("sweep lag L%0d e%0d", l, e), 32'(Q), 32'(e - l + 1));
                chk($sformatf("sweep fill L%0d e%0d", l, e), 32'(fill), (e < 4) ? e : 4);
            end
        end

        // Test 3: stall mid-stream
        flush();
        lat = 5'd3; CEN = 1'b1; D_vld = 1'b1;
        for (int v = 10; v <= 12; v++) begin
            D = W'(v);
            tick();
        end
        CEN = 1'b0; D = 18'd99;
        for (int s = 0; s < 5; s++) begin
            tick();
            #1;
            chk_all($sformatf("stall %0d", s));
            chk($sformatf("stall Q %0d", s), 32'(Q), 10);
            chk($sformatf("stall fill %0d", s), 32'(fill), 3);
        end
        CEN = 1'b1;
        for (int v = 13; v <= 15; v++) begin
            D = W'(v);
            tick();
            #1;
            chk_all($sformatf("resume %0d", v));
            chk($sformatf("resume Q %0d", v), 32'(Q), 32'(v - 2));
        end

        // Test 4: bubbles, fill tracks popcount; Q_vld at lat=4 replays the pattern
        flush();
        lat = 5'd4; CEN = 1'b1;
        for (int e = 0; e < 9; e++) begin
            D = W'(e + 40);
            D_vld = (e < 5) ? pat[e][0] : 1'b0;
            tick();
            #1;
            chk_all($sformatf("bubble e%0d", e));
            if (e < 5) chk($sformatf("bubble fill e%0d", e), 32'(fill), pfill[e]);
            if (e >= 3 && e < 8) chk($sformatf("bubble Q_vld e%0d", e), 32'(Q_vld), pat[e-3]);
        end

        // Test 5: flush with CEN low, then clr together with CEN and D_vld
        D_vld = 1'b1;
        for (int e = 0; e < 4; e++) begin
            D = W'(e + 60);
            tick();
        end
        chk("flush pre fill", 32'(fill), 4);
        CEN = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int l = 1; l <= 4; l++) begin
            lat = LAT_W'(l);
            #1;
            chk_all($sformatf("flushed L%0d", l));
            chk($sformatf("flushed Q L%0d", l), 32'(Q), 0);
        end
        CEN = 1'b1;
        repeat (2) tick();
        chk("refill", 32'(fill), 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr wins fill", 32'(fill), 0);
        chk_all("clr wins");

        // Test 6: out-of-range latency clamps and sets a sticky error
        D_vld = 1'b1;
        for (int e = 0; e < 5; e++) begin
            D = W'(e + 80);
            tick();
        end
        lat = 5'd7;
        #1 chk_all("badlat pre");
        chk("badlat clamp Q", 32'(Q), 81);
        chk("badlat err pre", 32'(lat_err), 0);
        tick();
        chk("badlat err set", 32'(lat_err), 1);
        lat = 5'd2;
        tick();
        #1 chk_all("badlat sticky");
        chk("badlat err sticky", 32'(lat_err), 1);
        flush();
        chk("badlat err cleared", 32'(lat_err), 0);
        chk_all("badlat end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
